// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared check-mode constants, fold and header field helpers for the router
package router_pkg;

  localparam int CHECK_XOR = 0;
  localparam int CHECK_SUM = 1;

  // Running integrity fold on a zero-extended byte; the caller narrows the
  // result to its byte width, which is where the sum carry is discarded.
  function automatic logic [31:0] fold(input logic [31:0] acc, input logic [31:0] b, input int mode);
    if (mode == CHECK_SUM) begin
      return acc + b;
    end
    return acc ^ b;
  endfunction

  // Destination address lives in the low addr_bits of the header.
  function automatic logic [31:0] hdr_addr(input logic [31:0] hdr, input int addr_bits);
    return hdr & ((32'd1 << addr_bits) - 32'd1);
  endfunction

  // Payload length is everything above the address field.
  function automatic logic [31:0] hdr_len(input logic [31:0] hdr, input int addr_bits);
    return hdr >> addr_bits;
  endfunction

endpackage

// File: rtl/router_hold_fifo.sv
// rtl/router_hold_fifo.sv - small tagged FIFO buffering bytes that arrive while the target FIFO is full
module router_hold_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] CAP  = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CAP);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; clr empties the buffer for a new packet.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage array carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/router_pkt_reg.sv
// rtl/router_pkt_reg.sv - router packet register: header latch, byte forwarding, stall buffering and packet checks
module router_pkt_reg
  import router_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_BITS  = 2,
  parameter int HOLD_DEPTH = 2,
  parameter int CHECK_MODE = 0
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  pkt_valid,
  input  logic                  fifo_full,
  input  logic                  detect_add,
  input  logic                  lfd_state,
  input  logic                  ld_state,
  input  logic                  laf_state,
  input  logic                  full_state,
  input  logic                  rst_int_reg,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  parity_done,
  output logic                  low_pkt_valid,
  output logic                  err,
  output logic                  len_err,
  output logic                  hold_empty,
  output logic                  hold_ovf
);

  localparam int LEN_W = DATA_WIDTH - ADDR_BITS;
  // One spare bit so an over-long packet is still distinguishable from the largest legal length.
  localparam int CNT_W = LEN_W + 1;

  logic [DATA_WIDTH-1:0] header;
  logic [DATA_WIDTH-1:0] accum;
  logic [DATA_WIDTH-1:0] packet_parity;
  logic [CNT_W-1:0]      count;
  logic                  pd_q;

  logic [DATA_WIDTH:0]   hold_wdata;
  logic [DATA_WIDTH:0]   hold_rdata;
  logic                  hold_full;
  logic                  hold_clr;
  logic                  hold_push;
  logic                  hold_pop;
  logic                  hold_drop;
  logic                  ld_act;
  logic                  laf_act;
  logic                  fwd;
  logic                  len_mismatch;

  // Strobe priority and byte routing: forward, park in the hold buffer, drop, or pop.
  always_comb begin
    hold_clr     = detect_add & pkt_valid;
    ld_act       = ~detect_add & ~lfd_state & ld_state & ~full_state;
    laf_act      = ~detect_add & ~lfd_state & ~ld_state & laf_state & ~full_state;
    fwd          = ld_act & ~fifo_full & hold_empty;
    hold_push    = ld_act & ~fwd & ~hold_full;
    hold_drop    = ld_act & ~fwd & hold_full;
    hold_pop     = laf_act & ~hold_empty;
    hold_wdata   = {~pkt_valid, data_in};
    len_mismatch = (count != CNT_W'(hdr_len(32'(header), ADDR_BITS)));
  end

  router_hold_fifo #(
    .DEPTH (HOLD_DEPTH),
    .WIDTH (DATA_WIDTH + 1)
  ) u_hold (
    .clk    (clk),
    .resetn (resetn),
    .clr    (hold_clr),
    .push   (hold_push),
    .pop    (hold_pop),
    .wdata  (hold_wdata),
    .rdata  (hold_rdata),
    .empty  (hold_empty),
    .full   (hold_full)
  );

  // Datapath: header latch, dout, running fold, payload count and per-packet status flags.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      header        <= '0;
      accum         <= '0;
      packet_parity <= '0;
      count         <= '0;
      dout          <= '0;
      parity_done   <= 1'b0;
      len_err       <= 1'b0;
      hold_ovf      <= 1'b0;
    end else if (detect_add) begin
      if (pkt_valid) begin
        header        <= data_in;
        accum         <= '0;
        packet_parity <= '0;
        count         <= '0;
        parity_done   <= 1'b0;
        len_err       <= 1'b0;
        hold_ovf      <= 1'b0;
      end
    end else if (lfd_state) begin
      dout  <= header;
      accum <= DATA_WIDTH'(fold(32'(accum), 32'(header), CHECK_MODE));
    end else if (ld_act) begin
      if (pkt_valid) begin
        accum <= DATA_WIDTH'(fold(32'(accum), 32'(data_in), CHECK_MODE));
        if (count == '1) len_err <= 1'b1;
        else             count   <= count + CNT_W'(1);
      end else begin
        packet_parity <= data_in;
      end
      if (fwd) begin
        dout <= data_in;
        if (!pkt_valid) begin
          parity_done <= 1'b1;
          if (!parity_done && len_mismatch) len_err <= 1'b1;
        end
      end
      if (hold_drop) hold_ovf <= 1'b1;
    end else if (hold_pop) begin
      dout <= hold_rdata[DATA_WIDTH-1:0];
      if (hold_rdata[DATA_WIDTH]) begin
        parity_done <= 1'b1;
        if (!parity_done && len_mismatch) len_err <= 1'b1;
      end
    end
  end

  // Packet verdict lands one edge after parity_done rises and holds until the next header.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      err  <= 1'b0;
      pd_q <= 1'b0;
    end else if (hold_clr) begin
      err  <= 1'b0;
      pd_q <= 1'b0;
    end else begin
      pd_q <= parity_done;
      if (parity_done && !pd_q) err <= (packet_parity != accum) | len_err | hold_ovf;
    end
  end

  // low_pkt_valid marks check-byte acceptance; only rst_int_reg clears it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      low_pkt_valid <= 1'b0;
    end else if (rst_int_reg) begin
      low_pkt_valid <= 1'b0;
    end else if (ld_act && !pkt_valid) begin
      low_pkt_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_router_pkt_reg.sv
// tb/tb_router_pkt_reg.sv - scoreboard bench for router_pkt_reg in XOR and SUM check modes
module tb_router_pkt_reg;

  localparam int DW = 8;
  localparam int HD = 2;

  logic          clk = 1'b0;
  logic          resetn = 1'b1;
  logic [DW-1:0] data_in;
  logic          pkt_valid, fifo_full, detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg;
  logic [DW-1:0] dout_x, dout_s;
  logic          pd_x, pd_s, lpv_x, lpv_s, err_x, err_s, le_x, le_s, he_x, he_s, ovf_x, ovf_s;

  always #5 clk = ~clk;

  router_pkt_reg #(.DATA_WIDTH(DW), .ADDR_BITS(2), .HOLD_DEPTH(HD), .CHECK_MODE(0)) u_xor (
    .clk(clk), .resetn(resetn), .data_in(data_in), .pkt_valid(pkt_valid), .fifo_full(fifo_full),
    .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state), .laf_state(laf_state),
    .full_state(full_state), .rst_int_reg(rst_int_reg), .dout(dout_x), .parity_done(pd_x),
    .low_pkt_valid(lpv_x), .err(err_x), .len_err(le_x), .hold_empty(he_x), .hold_ovf(ovf_x));

  router_pkt_reg #(.DATA_WIDTH(DW), .ADDR_BITS(2), .HOLD_DEPTH(HD), .CHECK_MODE(1)) u_sum (
    .clk(clk), .resetn(resetn), .data_in(data_in), .pkt_valid(pkt_valid), .fifo_full(fifo_full),
    .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state), .laf_state(laf_state),
    .full_state(full_state), .rst_int_reg(rst_int_reg), .dout(dout_s), .parity_done(pd_s),
    .low_pkt_valid(lpv_s), .err(err_s), .len_err(le_s), .hold_empty(he_s), .hold_ovf(ovf_s));

  typedef struct {
    logic [7:0] data;
    bit         chk;
    bit         ex;
    bit         es;
    bit         le;
    bit         ovf;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    bit         tag;
  } held_t;

  exp_t       dout_q[$];
  exp_t       cur;
  exp_t       pend;
  bit         err_pending = 1'b0;
  bit         out_evt = 1'b0;
  bit         out_evt_q = 1'b0;
  int         checks = 0;
  int         errors = 0;

  held_t      held[$];
  logic [7:0] tot_x, tot_s, chk_byte;
  bit         len_m, ovf_m;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  always @(posedge clk) out_evt_q <= out_evt;

  always @(negedge clk) begin
    if (resetn) begin
      if (err_pending) begin
        err_pending = 1'b0;
        check("err_xor", err_x, pend.ex);
        check("err_sum", err_s, pend.es);
        check("len_err_xor", le_x, pend.le);
        check("len_err_sum", le_s, pend.le);
        check("hold_ovf", ovf_x, pend.ovf);
        check("parity_done_stable", pd_x, 1);
        check("low_pkt_valid_cleared", lpv_x, 0);
      end
      if (out_evt_q) begin
        if (dout_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL dout_unexpected: got %0h expected no output", dout_x);
        end else begin
          cur = dout_q.pop_front();
          check("dout_xor", dout_x, cur.data);
          check("dout_sum", dout_s, cur.data);
          check("parity_done_xor", pd_x, cur.chk);
          check("parity_done_sum", pd_s, cur.chk);
          if (cur.chk) begin
            check("low_pkt_valid", lpv_x, 1);
            check("hold_empty_after_laf", he_x, 1);
            pend = cur;
            err_pending = 1'b1;
          end else begin
            check("err_mid_packet", err_x, 0);
          end
        end
      end
    end
  end

  function automatic void idle();
    detect_add = 0; lfd_state = 0; ld_state = 0; laf_state = 0; full_state = 0;
    pkt_valid = 0; fifo_full = 0; rst_int_reg = 0; data_in = '0; out_evt = 0;
  endfunction

  task automatic drive(input bit da, input bit lfd, input bit ld, input bit laf, input bit pv,
                       input bit ff, input bit rir, input logic [7:0] d, input bit evt);
    detect_add = da; lfd_state = lfd; ld_state = ld; laf_state = laf; full_state = 0;
    pkt_valid = pv; fifo_full = ff; rst_int_reg = rir; data_in = d; out_evt = evt;
    @(negedge clk);
  endtask

  function automatic void expect_out(input logic [7:0] d, input bit c);
    exp_t e;
    e.data = d;
    e.chk  = c;
    e.ex   = (chk_byte != tot_x) || len_m || ovf_m;
    e.es   = (chk_byte != tot_s) || len_m || ovf_m;
    e.le   = len_m;
    e.ovf  = ovf_m;
    dout_q.push_back(e);
  endfunction

  task automatic drain();
    held_t h;
    while (held.size() > 0) begin
      h = held.pop_front();
      expect_out(h.data, h.tag);
      drive(0, 0, 0, 1, 0, 0, 0, 8'($urandom), 1);
    end
  endtask

  // Plays one packet through the FSM strobes; stall[i] raises fifo_full for byte i (check byte last).
  task automatic send_pkt(input logic [7:0] hdr, input logic [7:0] pay[$], input logic [7:0] chk, input bit stall[$]);
    int np;
    logic [7:0] b;
    bit c;
    np = pay.size();
    tot_x = hdr;
    tot_s = hdr;
    foreach (pay[i]) begin
      tot_x = tot_x ^ pay[i];
      tot_s = tot_s + pay[i];
    end
    len_m = (np != int'(hdr >> 2));
    ovf_m = 0;
    chk_byte = chk;
    held.delete();
    drive(1, 0, 0, 0, 1, 0, 0, hdr, 0);
    expect_out(hdr, 0);
    drive(0, 1, 0, 0, 0, 0, 0, 8'($urandom), 1);
    for (int i = 0; i <= np; i++) begin
      c = (i == np);
      b = c ? chk : pay[i];
      if (stall[i]) begin
        if (c && held.size() == HD) drain();
        if (held.size() < HD) held.push_back('{b, c});
        else                  ovf_m = 1;
        drive(0, 0, 1, 0, !c, 1, 0, b, 0);
      end else begin
        drain();
        expect_out(b, c);
        drive(0, 0, 1, 0, !c, 0, 0, b, 1);
      end
    end
    drain();
    drive(0, 0, 0, 0, 0, 0, 1, 8'h00, 0);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_dout_x"}, dout_x, 0);
    check({tag, "_dout_s"}, dout_s, 0);
    check({tag, "_parity_done"}, pd_x | pd_s, 0);
    check({tag, "_low_pkt_valid"}, lpv_x | lpv_s, 0);
    check({tag, "_err"}, err_x | err_s, 0);
    check({tag, "_len_err"}, le_x | le_s, 0);
    check({tag, "_hold_ovf"}, ovf_x | ovf_s, 0);
    check({tag, "_hold_empty_x"}, he_x, 1);
    check({tag, "_hold_empty_s"}, he_s, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] pay[$];
    bit         st[$];
    logic [7:0] hdr, chk, tx, ts;
    int         len, np, r;

    idle();
    #1 resetn = 1'b0;
    #1 check_reset("reset");
    repeat (2) @(negedge clk);
    resetn = 1'b1;

    // Clean XOR packet, no stalls
    pay = '{8'h11, 8'h22, 8'h33}; st = '{0, 0, 0, 0};
    send_pkt(8'h0D, pay, 8'h0D, st);
    // Wrong check byte
    send_pkt(8'h0D, pay, 8'h0E, st);
    // Four payload bytes against a length of three
    pay = '{8'h11, 8'h22, 8'h33, 8'h44}; st = '{0, 0, 0, 0, 0};
    send_pkt(8'h0D, pay, 8'h0D, st);
    // Payload 22 and the check byte both parked, then drained in order
    pay = '{8'h11, 8'h22}; st = '{0, 1, 1};
    send_pkt(8'h09, pay, 8'h3A, st);
    // Three payload bytes under fifo_full overflow a two-entry buffer
    pay = '{8'h11, 8'h22, 8'h33}; st = '{1, 1, 1, 0};
    send_pkt(8'h0D, pay, 8'h0D, st);
    // Correct additive checksum
    st = '{0, 0, 0, 0};
    send_pkt(8'h0D, pay, 8'h73, st);

    for (int p = 0; p < 40; p++) begin
      pay.delete();
      st.delete();
      len = $urandom_range(0, 5);
      r = $urandom_range(0, 5);
      np = (r == 0) ? len + 1 : ((r == 1 && len > 0) ? len - 1 : len);
      hdr = 8'((len << 2) | $urandom_range(0, 3));
      tx = hdr;
      ts = hdr;
      for (int i = 0; i < np; i++) begin
        pay.push_back(8'($urandom));
        tx = tx ^ pay[i];
        ts = ts + pay[i];
      end
      case ($urandom_range(0, 3))
        0, 1:    chk = tx;
        2:       chk = ts;
        default: chk = 8'($urandom);
      endcase
      for (int i = 0; i <= np; i++) st.push_back($urandom_range(0, 2) == 0);
      send_pkt(hdr, pay, chk, st);
    end

    // Reset in the middle of a packet with a byte parked in the hold buffer
    drive(1, 0, 0, 0, 1, 0, 0, 8'h0D, 0);
    expect_out(8'h0D, 0);
    drive(0, 1, 0, 0, 0, 0, 0, 8'h00, 1);
    expect_out(8'h11, 0);
    drive(0, 0, 1, 0, 1, 0, 0, 8'h11, 1);
    drive(0, 0, 1, 0, 1, 1, 0, 8'h22, 0);
    idle();
    check("pre_reset_hold_empty", he_s, 0);
    check("pre_reset_dout", dout_s, 8'h11);
    @(posedge clk);
    #2 resetn = 1'b0;
    #1 check_reset("mid_reset");
    dout_q.delete();
    @(negedge clk);
    resetn = 1'b1;

    repeat (3) @(negedge clk);
    check("scoreboard_drained", dout_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/router_pkt_reg.md
# router_pkt_reg

Parametrised packet register and integrity-check block for the router datapath. It sits between the input port and the FSM-driven FIFO write path, under control of the router FSM state strobes. It latches the header, forwards header, payload and check bytes to the FIFOs, and buffers bytes that arrive while the target FIFO is full. It checks each packet against a selectable XOR-parity or additive checksum, and against the header length field.

## Interface
Parameters:
- DATA_WIDTH, 8: byte width of data_in/dout.
- ADDR_BITS, 2: header LSBs holding the destination address; header[DATA_WIDTH-1:ADDR_BITS] is the payload length.
- HOLD_DEPTH, 2: entries in the full-stall hold buffer, minimum 1.
- CHECK_MODE, 0: 0 = XOR parity, 1 = modulo-2^DATA_WIDTH sum checksum.

Ports:
- clk  in  1  single clock; all registers on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- data_in  in  DATA_WIDTH  input byte.
- pkt_valid  in  1  high for header and payload bytes, low for the check byte.
- fifo_full  in  1  full flag of the selected FIFO.
- detect_add, lfd_state, ld_state, laf_state, full_state  in  1 each  FSM state strobes.
- rst_int_reg  in  1  clears low_pkt_valid.
- dout  out  DATA_WIDTH  byte to FIFO write port.
- parity_done  out  1  the check byte has been driven on dout.
- low_pkt_valid  out  1  the check byte has been accepted.
- err  out  1  packet failed a check.
- len_err  out  1  payload count does not equal the header length.
- hold_empty  out  1  hold buffer holds no bytes.
- hold_ovf  out  1  a byte was dropped because the hold buffer was full.

## Operation
- Strobe priority: detect_add > lfd_state > ld_state > laf_state. The FSM keeps strobes exclusive; the priority applies if they overlap.
- detect_add & pkt_valid:
  - header <= data_in.
  - Clear accum, packet_parity, payload count, parity_done, err, len_err, hold_ovf and the hold buffer.
  - dout holds its value.
- lfd_state: dout <= header; accum <= fold(accum, header).
- ld_state with a byte accepted, whether forwarded or pushed:
  - pkt_valid=1: accum <= fold(accum, data_in); count increments and saturates; saturation sets len_err.
  - pkt_valid=0: packet_parity <= data_in; low_pkt_valid <= 1.
- ld_state routing:
  - fifo_full=0 and hold_empty: dout <= data_in. If it is the check byte, parity_done <= 1 on the same edge.
  - fifo_full=1: push {tag=!pkt_valid, data_in} into the hold buffer.
  - Buffer already holds HOLD_DEPTH bytes: the byte is dropped, hold_ovf <= 1 (sticky), and accum/count are still updated.
- laf_state and hold buffer not empty: pop the head onto dout, one per cycle, in order. A tagged head sets parity_done <= 1 on the same edge. Popping stops when the buffer is empty; hold_empty tells the FSM when LAF is complete.
- fold: XOR mode gives accum ^ byte; SUM mode gives (accum + byte) mod 2^DATA_WIDTH. The carry is discarded.
- len_err is also set on the edge parity_done rises if count != header length.
- err <= (packet_parity != accum) | len_err | hold_ovf. It is registered on the edge after parity_done rises and holds until detect_add or reset.
- rst_int_reg clears low_pkt_valid; detect_add does not.

## Timing
- Asynchronous reset drives every register and output to 0. The exception is hold_empty, which resets to 1. Reset mid-packet discards all state immediately.
- dout latency is 1 clock from a sampled strobe. A held byte is delayed by the stall length plus 1.
- err is valid 1 cycle after parity_done rises. It is stable while parity_done=1.
- Push while a pop is in progress cannot occur, because ld_state and laf_state are exclusive.
- full_state has no effect on the datapath. No byte is accepted or popped in full_state.

## Structure
- Shared package router_pkg:
  - CHECK_XOR / CHECK_SUM constants.
  - The fold function.
  - Header field helpers for address and length extraction by ADDR_BITS.
- Sub-module router_hold_fifo: a HOLD_DEPTH x (DATA_WIDTH+1) tagged FIFO with push, pop, empty, full and async reset. The top level contains the header, accum, count, check and flag registers.

## Test plan
- XOR mode, DATA_WIDTH 8: header 8'h0D, payload 11/22/33, check 8'h0D, no stalls -> dout sequence 0D,11,22,33,0D; parity_done=1; err=0; len_err=0.
- Same packet with check 8'h0E -> err=1 one cycle after parity_done, cleared by the next detect_add.
- Header 8'h0D (length 3) with 4 payload bytes -> len_err=1, err=1.
- fifo_full high for payload 22 and the check byte, HOLD_DEPTH 2 -> both are held; laf pops 22 then the check byte; parity_done rises with the check byte on dout; hold_empty returns to 1; err=0.
- HOLD_DEPTH 2 with 3 bytes pushed under fifo_full -> hold_ovf=1, 3rd byte absent from dout, err=1.
- CHECK_MODE 1: header 0D with payload 11/22/33 and check 8'h73 gives err=0. Then assert resetn=0 mid-payload -> all outputs 0 and hold_empty=1 with no clock edge.
